// File: rtl/cdb_writeback_if.sv
// Common data bus beat interface between the CDB arbiter and the writeback stage.
// The arbiter drives a beat and its valid; the writeback stage returns ready.
interface cdb_writeback_if #(
    parameter int XLEN  = 32,
    parameter int PD_W  = 10,
    parameter int ROB_W = 6
);
    logic             cdb_valid;
    logic             cdb_ready;
    logic [XLEN-1:0]  cdb_value;
    logic [4:0]       cdb_rd;
    logic [PD_W-1:0]  cdb_pd;
    logic [ROB_W-1:0] cdb_rob;
    logic             cdb_we;
    logic             cdb_is_ctrl;
    logic             cdb_br_taken;
    logic [31:0]      cdb_br_target;
    logic [31:0]      cdb_pc;

    modport master (
        output cdb_valid, cdb_value, cdb_rd, cdb_pd, cdb_rob, cdb_we,
               cdb_is_ctrl, cdb_br_taken, cdb_br_target, cdb_pc,
        input  cdb_ready
    );

    modport slave (
        input  cdb_valid, cdb_value, cdb_rd, cdb_pd, cdb_rob, cdb_we,
               cdb_is_ctrl, cdb_br_taken, cdb_br_target, cdb_pc,
        output cdb_ready
    );
endinterface

// File: rtl/cdb_writeback.sv
// CDB writeback stage: buffers accepted CDB beats in an in-order FIFO and
// retires the head beat in one cycle as a PRF write, RS wakeup, ROB completion
// and branch-resolution report, all firing together.
module cdb_writeback #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    parameter int PD_W  = 10,
    parameter int ROB_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    cdb_writeback_if.slave   cdb,
    input  logic             flush,
    input  logic             prf_grant,
    output logic             prf_we,
    output logic [PD_W-1:0]  prf_waddr,
    output logic [XLEN-1:0]  prf_wdata,
    output logic             wake_valid,
    output logic [PD_W-1:0]  wake_pd,
    output logic             rob_cmp_valid,
    output logic [ROB_W-1:0] rob_cmp_idx,
    output logic             br_res_valid,
    output logic             br_res_taken,
    output logic [31:0]      br_res_target,
    output logic [31:0]      br_res_pc,
    output logic [ROB_W-1:0] br_res_rob,
    output logic [31:0]      wb_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [XLEN-1:0]  value;
        logic [4:0]       rd;
        logic [PD_W-1:0]  pd;
        logic [ROB_W-1:0] rob;
        logic             we;
        logic             needs_prf;
        logic             is_ctrl;
        logic             br_taken;
        logic [31:0]      br_target;
        logic [31:0]      pc;
    } entry_t;

    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      wb_count_q, wb_count_d;

    entry_t           head_s;
    entry_t           in_s;
    logic             hv_s;
    logic             full_s;
    logic             ready_s;
    logic             push_s;
    logic             pop_s;
    logic             unused_s;

    // Handshake and retire decisions; ready depends only on occupancy and flush.
    always_comb begin
        head_s  = mem_q[head_q];
        hv_s    = (count_q != CNT_W'(0));
        full_s  = (count_q == CNT_W'(DEPTH));
        ready_s = !full_s && !flush;
        push_s  = cdb.cdb_valid && ready_s;
        pop_s   = hv_s && (!head_s.needs_prf || prf_grant) && !flush;

        in_s.value     = cdb.cdb_value;
        in_s.rd        = cdb.cdb_rd;
        in_s.pd        = cdb.cdb_pd;
        in_s.rob       = cdb.cdb_rob;
        in_s.we        = cdb.cdb_we;
        in_s.needs_prf = cdb.cdb_we && (cdb.cdb_pd != PD_W'(0));
        in_s.is_ctrl   = cdb.cdb_is_ctrl;
        in_s.br_taken  = cdb.cdb_br_taken;
        in_s.br_target = cdb.cdb_br_target;
        in_s.pc        = cdb.cdb_pc;
    end

    assign cdb.cdb_ready = ready_s;

    // rd and we travel with the beat for debug visibility; retire only needs needs_prf.
    assign unused_s = ^{head_s.rd, head_s.we};

    // FIFO next-state: push at tail, pop at head, flush empties, retire counter saturates.
    always_comb begin
        mem_d      = mem_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        wb_count_d = wb_count_q;

        if (flush) begin
            count_d = CNT_W'(0);
            head_d  = tail_q;
        end else begin
            if (push_s) begin
                mem_d[tail_q] = in_s;
                tail_d        = tail_q + PTR_W'(1);
            end else begin
                tail_d = tail_q;
            end

            if (pop_s) begin
                head_d = head_q + PTR_W'(1);
                if (wb_count_q != 32'hFFFF_FFFF) begin
                    wb_count_d = wb_count_q + 32'd1;
                end else begin
                    wb_count_d = wb_count_q;
                end
            end else begin
                head_d = head_q;
            end

            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Retire outputs: strobes only on pop; data shows the head entry or zero when empty.
    always_comb begin
        prf_we        = pop_s && head_s.needs_prf;
        wake_valid    = pop_s && head_s.needs_prf;
        rob_cmp_valid = pop_s;
        br_res_valid  = pop_s && head_s.is_ctrl;

        if (hv_s) begin
            prf_waddr     = head_s.pd;
            prf_wdata     = head_s.value;
            wake_pd       = head_s.pd;
            rob_cmp_idx   = head_s.rob;
            br_res_taken  = head_s.br_taken;
            br_res_target = head_s.br_target;
            br_res_pc     = head_s.pc;
            br_res_rob    = head_s.rob;
        end else begin
            prf_waddr     = PD_W'(0);
            prf_wdata     = XLEN'(0);
            wake_pd       = PD_W'(0);
            rob_cmp_idx   = ROB_W'(0);
            br_res_taken  = 1'b0;
            br_res_target = 32'd0;
            br_res_pc     = 32'd0;
            br_res_rob    = ROB_W'(0);
        end
    end

    assign wb_count = wb_count_q;

    // State registers with asynchronous active-low reset discarding all beats.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            head_q     <= PTR_W'(0);
            tail_q     <= PTR_W'(0);
            count_q    <= CNT_W'(0);
            wb_count_q <= 32'd0;
        end else begin
            mem_q      <= mem_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            wb_count_q <= wb_count_d;
        end
    end

endmodule

// File: tb/tb_cdb_writeback.sv
// Self-checking bench for cdb_writeback: accepted beats are pushed to an
// expectation queue and popped/compared when the DUT retires them.
module tb_cdb_writeback;
    localparam int XLEN  = 32;
    localparam int DEPTH = 2;
    localparam int PD_W  = 10;
    localparam int ROB_W = 6;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             flush = 1'b0;
    logic             prf_grant = 1'b0;
    logic             prf_we;
    logic [PD_W-1:0]  prf_waddr;
    logic [XLEN-1:0]  prf_wdata;
    logic             wake_valid;
    logic [PD_W-1:0]  wake_pd;
    logic             rob_cmp_valid;
    logic [ROB_W-1:0] rob_cmp_idx;
    logic             br_res_valid;
    logic             br_res_taken;
    logic [31:0]      br_res_target;
    logic [31:0]      br_res_pc;
    logic [ROB_W-1:0] br_res_rob;
    logic [31:0]      wb_count;

    cdb_writeback_if #(.XLEN(XLEN), .PD_W(PD_W), .ROB_W(ROB_W)) cdb ();

    cdb_writeback #(.XLEN(XLEN), .DEPTH(DEPTH), .PD_W(PD_W), .ROB_W(ROB_W)) dut (
        .clk(clk), .rst(rst), .cdb(cdb), .flush(flush), .prf_grant(prf_grant),
        .prf_we(prf_we), .prf_waddr(prf_waddr), .prf_wdata(prf_wdata),
        .wake_valid(wake_valid), .wake_pd(wake_pd),
        .rob_cmp_valid(rob_cmp_valid), .rob_cmp_idx(rob_cmp_idx),
        .br_res_valid(br_res_valid), .br_res_taken(br_res_taken),
        .br_res_target(br_res_target), .br_res_pc(br_res_pc),
        .br_res_rob(br_res_rob), .wb_count(wb_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [PD_W-1:0]  pd;
        logic [XLEN-1:0]  value;
        logic [ROB_W-1:0] rob;
        logic             needs_prf;
        logic             is_ctrl;
        logic             taken;
        logic [31:0]      target;
        logic [31:0]      pc;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    exp_t e;
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [PD_W-1:0] pd, input logic [XLEN-1:0] value,
                         input logic [ROB_W-1:0] rob, input logic we, input logic ctrl,
                         input logic taken, input logic [31:0] target, input logic [31:0] pc);
        cdb.cdb_valid     = 1'b1;
        cdb.cdb_value     = value;
        cdb.cdb_rd        = 5'd7;
        cdb.cdb_pd        = pd;
        cdb.cdb_rob       = rob;
        cdb.cdb_we        = we;
        cdb.cdb_is_ctrl   = ctrl;
        cdb.cdb_br_taken  = taken;
        cdb.cdb_br_target = target;
        cdb.cdb_pc        = pc;
        cur.pd        = pd;
        cur.value     = value;
        cur.rob       = rob;
        cur.needs_prf = we && (pd != PD_W'(0));
        cur.is_ctrl   = ctrl;
        cur.taken     = taken;
        cur.target    = target;
        cur.pc        = pc;
    endtask

    task automatic idle();
        cdb.cdb_valid = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        total_cnt++; if (prf_we !== 1'b0) $display("FAIL reset_prf_we: got %0h want 0", prf_we); else pass_cnt++;
        total_cnt++; if (rob_cmp_valid !== 1'b0) $display("FAIL reset_rob_cmp_valid: got %0h want 0", rob_cmp_valid); else pass_cnt++;
        total_cnt++; if (prf_wdata !== 32'd0) $display("FAIL reset_prf_wdata: got %0h want 0", prf_wdata); else pass_cnt++;
        total_cnt++; if (wb_count !== 32'd0) $display("FAIL reset_wb_count: got %0h want 0", wb_count); else pass_cnt++;
        #9;
        rst = 1'b1;
        tick();
        @(negedge clk);
        total_cnt++; if (cdb.cdb_ready !== 1'b1) $display("FAIL reset_ready: got %0h want 1", cdb.cdb_ready); else pass_cnt++;
        total_cnt++; if (br_res_valid !== 1'b0) $display("FAIL reset_br_valid: got %0h want 0", br_res_valid); else pass_cnt++;
    endtask

    task automatic test_single();
        tick();
        prf_grant = 1'b1;
        drive(10'h005, 32'h1234, 6'd3, 1'b1, 1'b0, 1'b0, 32'd0, 32'h100);
        exp_q.push_back(cur);
        @(negedge clk);
        total_cnt++; if (cdb.cdb_ready !== 1'b1) $display("FAIL single_ready: got %0h want 1", cdb.cdb_ready); else pass_cnt++;
        total_cnt++; if (rob_cmp_valid !== 1'b0) $display("FAIL single_no_bypass: got %0h want 0", rob_cmp_valid); else pass_cnt++;
        tick();
        idle();
        @(negedge clk);
        e = exp_q.pop_front();
        total_cnt++; if (rob_cmp_valid !== 1'b1) $display("FAIL single_rob_valid: got %0h want 1", rob_cmp_valid); else pass_cnt++;
        total_cnt++; if (rob_cmp_idx !== e.rob) $display("FAIL single_rob_idx: got %0h want %0h", rob_cmp_idx, e.rob); else pass_cnt++;
        total_cnt++; if (prf_we !== e.needs_prf) $display("FAIL single_prf_we: got %0h want %0h", prf_we, e.needs_prf); else pass_cnt++;
        total_cnt++; if (prf_waddr !== e.pd) $display("FAIL single_prf_waddr: got %0h want %0h", prf_waddr, e.pd); else pass_cnt++;
        total_cnt++; if (prf_wdata !== e.value) $display("FAIL single_prf_wdata: got %0h want %0h", prf_wdata, e.value); else pass_cnt++;
        total_cnt++; if (wake_valid !== e.needs_prf) $display("FAIL single_wake_valid: got %0h want %0h", wake_valid, e.needs_prf); else pass_cnt++;
        total_cnt++; if (wake_pd !== e.pd) $display("FAIL single_wake_pd: got %0h want %0h", wake_pd, e.pd); else pass_cnt++;
        total_cnt++; if (br_res_valid !== e.is_ctrl) $display("FAIL single_br_valid: got %0h want %0h", br_res_valid, e.is_ctrl); else pass_cnt++;
        tick();
        @(negedge clk);
        total_cnt++; if ({prf_we, wake_valid, rob_cmp_valid} !== 3'b000) $display("FAIL single_idle_strobes: got %0b want 000", {prf_we, wake_valid, rob_cmp_valid}); else pass_cnt++;
        total_cnt++; if (wb_count !== 32'd1) $display("FAIL single_wb_count: got %0d want 1", wb_count); else pass_cnt++;
    endtask

    task automatic test_store_no_grant();
        tick();
        prf_grant = 1'b0;
        drive(10'h011, 32'hDEAD, 6'd7, 1'b0, 1'b0, 1'b0, 32'd0, 32'h200);
        exp_q.push_back(cur);
        tick();
        idle();
        @(negedge clk);
        e = exp_q.pop_front();
        total_cnt++; if (rob_cmp_valid !== 1'b1) $display("FAIL store_rob_valid: got %0h want 1", rob_cmp_valid); else pass_cnt++;
        total_cnt++; if (rob_cmp_idx !== e.rob) $display("FAIL store_rob_idx: got %0h want %0h", rob_cmp_idx, e.rob); else pass_cnt++;
        total_cnt++; if (prf_we !== 1'b0) $display("FAIL store_prf_we: got %0h want 0", prf_we); else pass_cnt++;
        total_cnt++; if (wake_valid !== 1'b0) $display("FAIL store_wake_valid: got %0h want 0", wake_valid); else pass_cnt++;
        tick();
        @(negedge clk);
        total_cnt++; if (wb_count !== 32'd2) $display("FAIL store_wb_count: got %0d want 2", wb_count); else pass_cnt++;
    endtask

    task automatic test_pd_zero();
        tick();
        prf_grant = 1'b0;
        drive(10'h000, 32'hBEEF, 6'd4, 1'b1, 1'b0, 1'b0, 32'd0, 32'h300);
        exp_q.push_back(cur);
        tick();
        idle();
        @(negedge clk);
        e = exp_q.pop_front();
        total_cnt++; if (rob_cmp_valid !== 1'b1) $display("FAIL pd0_rob_valid: got %0h want 1", rob_cmp_valid); else pass_cnt++;
        total_cnt++; if (rob_cmp_idx !== e.rob) $display("FAIL pd0_rob_idx: got %0h want %0h", rob_cmp_idx, e.rob); else pass_cnt++;
        total_cnt++; if (prf_we !== 1'b0) $display("FAIL pd0_prf_we: got %0h want 0", prf_we); else pass_cnt++;
        tick();
        @(negedge clk);
        total_cnt++; if (wb_count !== 32'd3) $display("FAIL pd0_wb_count: got %0d want 3", wb_count); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        tick();
        prf_grant = 1'b0;
        drive(10'h021, 32'hA1, 6'd1, 1'b1, 1'b0, 1'b0, 32'd0, 32'h400);
        exp_q.push_back(cur);
        @(negedge clk);
        total_cnt++; if (cdb.cdb_ready !== 1'b1) $display("FAIL b2b_ready_1: got %0h want 1", cdb.cdb_ready); else pass_cnt++;
        tick();
        drive(10'h022, 32'hA2, 6'd2, 1'b1, 1'b0, 1'b0, 32'd0, 32'h404);
        exp_q.push_back(cur);
        @(negedge clk);
        total_cnt++; if (cdb.cdb_ready !== 1'b1) $display("FAIL b2b_ready_2: got %0h want 1", cdb.cdb_ready); else pass_cnt++;
        total_cnt++; if (rob_cmp_valid !== 1'b0) $display("FAIL b2b_stall_no_grant: got %0h want 0", rob_cmp_valid); else pass_cnt++;
        total_cnt++; if (prf_waddr !== 10'h021) $display("FAIL b2b_head_hold: got %0h want 21", prf_waddr); else pass_cnt++;
        tick();
        drive(10'h023, 32'hA3, 6'd3, 1'b1, 1'b0, 1'b0, 32'd0, 32'h408);
        @(negedge clk);
        total_cnt++; if (cdb.cdb_ready !== 1'b0) $display("FAIL b2b_full_ready: got %0h want 0", cdb.cdb_ready); else pass_cnt++;
        tick();
        prf_grant = 1'b1;
        @(negedge clk);
        total_cnt++; if (cdb.cdb_ready !== 1'b0) $display("FAIL b2b_no_passthru: got %0h want 0", cdb.cdb_ready); else pass_cnt++;
        e = exp_q.pop_front();
        total_cnt++; if (rob_cmp_valid !== 1'b1) $display("FAIL b2b_first_valid: got %0h want 1", rob_cmp_valid); else pass_cnt++;
        total_cnt++; if (rob_cmp_idx !== e.rob) $display("FAIL b2b_first_idx: got %0h want %0h", rob_cmp_idx, e.rob); else pass_cnt++;
        tick();
        @(negedge clk);
        total_cnt++; if (cdb.cdb_ready !== 1'b1) $display("FAIL b2b_ready_after_pop: got %0h want 1", cdb.cdb_ready); else pass_cnt++;
        exp_q.push_back(cur);
        e = exp_q.pop_front();
        total_cnt++; if (rob_cmp_idx !== e.rob) $display("FAIL b2b_second_idx: got %0h want %0h", rob_cmp_idx, e.rob); else pass_cnt++;
        total_cnt++; if (prf_wdata !== e.value) $display("FAIL b2b_second_data: got %0h want %0h", prf_wdata, e.value); else pass_cnt++;
        tick();
        idle();
        @(negedge clk);
        e = exp_q.pop_front();
        total_cnt++; if (rob_cmp_valid !== 1'b1) $display("FAIL b2b_third_valid: got %0h want 1", rob_cmp_valid); else pass_cnt++;
        total_cnt++; if (rob_cmp_idx !== e.rob) $display("FAIL b2b_third_idx: got %0h want %0h", rob_cmp_idx, e.rob); else pass_cnt++;
        total_cnt++; if (prf_waddr !== e.pd) $display("FAIL b2b_third_pd: got %0h want %0h", prf_waddr, e.pd); else pass_cnt++;
        tick();
        @(negedge clk);
        total_cnt++; if (rob_cmp_valid !== 1'b0) $display("FAIL b2b_drained: got %0h want 0", rob_cmp_valid); else pass_cnt++;
        total_cnt++; if (wb_count !== 32'd6) $display("FAIL b2b_wb_count: got %0d want 6", wb_count); else pass_cnt++;
    endtask

    task automatic test_branch();
        tick();
        prf_grant = 1'b1;
        drive(10'h030, 32'h55, 6'd9, 1'b1, 1'b1, 1'b1, 32'h8000_0040, 32'h8000_0010);
        exp_q.push_back(cur);
        tick();
        idle();
        @(negedge clk);
        e = exp_q.pop_front();
        total_cnt++; if ({br_res_valid, rob_cmp_valid, prf_we} !== 3'b111) $display("FAIL br_strobes: got %0b want 111", {br_res_valid, rob_cmp_valid, prf_we}); else pass_cnt++;
        total_cnt++; if (br_res_taken !== e.taken) $display("FAIL br_taken: got %0h want %0h", br_res_taken, e.taken); else pass_cnt++;
        total_cnt++; if (br_res_target !== e.target) $display("FAIL br_target: got %0h want %0h", br_res_target, e.target); else pass_cnt++;
        total_cnt++; if (br_res_pc !== e.pc) $display("FAIL br_pc: got %0h want %0h", br_res_pc, e.pc); else pass_cnt++;
        total_cnt++; if (br_res_rob !== e.rob) $display("FAIL br_rob: got %0h want %0h", br_res_rob, e.rob); else pass_cnt++;
        tick();
        @(negedge clk);
        total_cnt++; if (br_res_valid !== 1'b0) $display("FAIL br_after: got %0h want 0", br_res_valid); else pass_cnt++;
        total_cnt++; if (wb_count !== 32'd7) $display("FAIL br_wb_count: got %0d want 7", wb_count); else pass_cnt++;
    endtask

    task automatic test_flush();
        tick();
        prf_grant = 1'b0;
        drive(10'h031, 32'hF1, 6'd10, 1'b1, 1'b0, 1'b0, 32'd0, 32'h500);
        tick();
        drive(10'h032, 32'hF2, 6'd11, 1'b1, 1'b0, 1'b0, 32'd0, 32'h504);
        tick();
        idle();
        flush = 1'b1;
        prf_grant = 1'b1;
        @(negedge clk);
        total_cnt++; if (cdb.cdb_ready !== 1'b0) $display("FAIL flush_ready: got %0h want 0", cdb.cdb_ready); else pass_cnt++;
        total_cnt++; if ({rob_cmp_valid, prf_we, wake_valid, br_res_valid} !== 4'b0000) $display("FAIL flush_strobes: got %0b want 0000", {rob_cmp_valid, prf_we, wake_valid, br_res_valid}); else pass_cnt++;
        tick();
        flush = 1'b0;
        @(negedge clk);
        total_cnt++; if (cdb.cdb_ready !== 1'b1) $display("FAIL flush_ready_after: got %0h want 1", cdb.cdb_ready); else pass_cnt++;
        total_cnt++; if (rob_cmp_valid !== 1'b0) $display("FAIL flush_emptied: got %0h want 0", rob_cmp_valid); else pass_cnt++;
        tick();
        @(negedge clk);
        total_cnt++; if (wb_count !== 32'd7) $display("FAIL flush_wb_count: got %0d want 7", wb_count); else pass_cnt++;
    endtask

    task automatic test_async_reset();
        tick();
        prf_grant = 1'b0;
        drive(10'h033, 32'hC1, 6'd12, 1'b1, 1'b0, 1'b0, 32'd0, 32'h600);
        tick();
        drive(10'h034, 32'hC2, 6'd13, 1'b1, 1'b0, 1'b0, 32'd0, 32'h604);
        tick();
        idle();
        @(negedge clk);
        total_cnt++; if (cdb.cdb_ready !== 1'b0) $display("FAIL arst_full: got %0h want 0", cdb.cdb_ready); else pass_cnt++;
        #1;
        prf_grant = 1'b1;
        #1;
        total_cnt++; if (rob_cmp_idx !== 6'd12) $display("FAIL arst_pre_head: got %0h want c", rob_cmp_idx); else pass_cnt++;
        rst = 1'b0;
        #1;
        total_cnt++; if ({rob_cmp_valid, prf_we, wake_valid} !== 3'b000) $display("FAIL arst_strobes: got %0b want 000", {rob_cmp_valid, prf_we, wake_valid}); else pass_cnt++;
        total_cnt++; if (prf_waddr !== 10'h000) $display("FAIL arst_waddr: got %0h want 0", prf_waddr); else pass_cnt++;
        total_cnt++; if (wb_count !== 32'd0) $display("FAIL arst_wb_count: got %0d want 0", wb_count); else pass_cnt++;
        @(posedge clk);
        #2;
        rst = 1'b1;
        @(negedge clk);
        total_cnt++; if (cdb.cdb_ready !== 1'b1) $display("FAIL arst_ready: got %0h want 1", cdb.cdb_ready); else pass_cnt++;
        total_cnt++; if (rob_cmp_valid !== 1'b0) $display("FAIL arst_no_retire: got %0h want 0", rob_cmp_valid); else pass_cnt++;
        tick();
        @(negedge clk);
        total_cnt++; if (wb_count !== 32'd0) $display("FAIL arst_wb_after: got %0d want 0", wb_count); else pass_cnt++;
    endtask

    initial begin
        cdb.cdb_valid     = 1'b0;
        cdb.cdb_value     = 32'd0;
        cdb.cdb_rd        = 5'd0;
        cdb.cdb_pd        = 10'd0;
        cdb.cdb_rob       = 6'd0;
        cdb.cdb_we        = 1'b0;
        cdb.cdb_is_ctrl   = 1'b0;
        cdb.cdb_br_taken  = 1'b0;
        cdb.cdb_br_target = 32'd0;
        cdb.cdb_pc        = 32'd0;
        test_reset();
        test_single();
        test_store_no_grant();
        test_pd_zero();
        test_back_to_back();
        test_branch();
        test_flush();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "timeout");
    end

endmodule
